// File: rtl/fdtd_mem_word_wr.sv
// Single-word AXI4 write master: latches one word request, issues AW+W as a
// single beat, waits for B and returns a one-cycle grant with error status.
module fdtd_mem_word_wr #(
  parameter int AXI4_ADDR_WIDTH = 32,
  parameter int AXI4_DATA_WIDTH = 32,
  parameter int AXI4_ID_WIDTH   = 16,
  parameter int AXI4_USER_WIDTH = 10,
  parameter int AXI_STRB_WIDTH  = AXI4_DATA_WIDTH / 8
) (
  input  logic                         ACLK,
  input  logic                         ARESET,
  output logic [AXI4_ID_WIDTH-1:0]     AWID_o,
  output logic [AXI4_ADDR_WIDTH-1:0]   AWADDR_o,
  output logic [7:0]                   AWLEN_o,
  output logic [2:0]                   AWSIZE_o,
  output logic [1:0]                   AWBURST_o,
  output logic                         AWLOCK_o,
  output logic [3:0]                   AWCACHE_o,
  output logic [2:0]                   AWPROT_o,
  output logic [3:0]                   AWREGION_o,
  output logic [AXI4_USER_WIDTH-1:0]   AWUSER_o,
  output logic [3:0]                   AWQOS_o,
  output logic                         AWVALID_o,
  input  logic                         AWREADY_i,
  output logic [AXI4_DATA_WIDTH-1:0]   WDATA_o,
  output logic [AXI_STRB_WIDTH-1:0]    WSTRB_o,
  output logic                         WLAST_o,
  output logic [AXI4_USER_WIDTH-1:0]   WUSER_o,
  output logic                         WVALID_o,
  input  logic                         WREADY_i,
  input  logic [AXI4_ID_WIDTH-1:0]     BID_i,
  input  logic [1:0]                   BRESP_i,
  input  logic                         BVALID_i,
  input  logic [AXI4_USER_WIDTH-1:0]   BUSER_i,
  output logic                         BREADY_o,
  input  logic                         wr_req_i,
  input  logic [AXI4_ADDR_WIDTH-3:0]   wr_word_addr_i,
  input  logic [AXI4_DATA_WIDTH-1:0]   wr_data_i,
  input  logic [AXI_STRB_WIDTH-1:0]    wr_strb_i,
  output logic                         wr_gnt_o,
  output logic                         wr_err_o
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_B} state_t;

  localparam logic [2:0] BEAT_SIZE = 3'($clog2(AXI_STRB_WIDTH));

  state_t                       state;
  logic                         aw_done;
  logic                         w_done;
  logic                         aw_hs;
  logic                         w_hs;
  logic [AXI4_ADDR_WIDTH-3:0]   addr_q;
  logic [AXI4_DATA_WIDTH-1:0]   data_q;
  logic [AXI_STRB_WIDTH-1:0]    strb_q;
  logic                         unused_inputs;

  assign AWID_o     = '0;
  assign AWLEN_o    = 8'd0;
  assign AWSIZE_o   = BEAT_SIZE;
  assign AWBURST_o  = 2'b01;
  assign AWLOCK_o   = 1'b0;
  assign AWCACHE_o  = 4'd0;
  assign AWPROT_o   = 3'd0;
  assign AWREGION_o = 4'd0;
  assign AWUSER_o   = '0;
  assign AWQOS_o    = 4'd0;
  assign WLAST_o    = 1'b1;
  assign WUSER_o    = '0;

  assign AWADDR_o = {addr_q, 2'b00};
  assign WDATA_o  = data_q;
  assign WSTRB_o  = strb_q;

  assign aw_hs    = AWVALID_o & AWREADY_i;
  assign w_hs     = WVALID_o & WREADY_i;
  assign BREADY_o = (state == WAIT_B);
  // Grant follows BVALID in the same cycle; EXOKAY (2'b01) counts as success.
  assign wr_gnt_o = (state == WAIT_B) & BVALID_i;
  assign wr_err_o = wr_gnt_o & BRESP_i[1];

  assign unused_inputs = ^{BID_i, BUSER_i, BRESP_i[0]};

  // AW and W retire independently; WAIT_B is entered once both have handshaken.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state     <= IDLE;
      AWVALID_o <= 1'b0;
      WVALID_o  <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      strb_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_req_i) begin
            addr_q    <= wr_word_addr_i;
            data_q    <= wr_data_i;
            strb_q    <= wr_strb_i;
            AWVALID_o <= 1'b1;
            WVALID_o  <= 1'b1;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            state     <= SEND;
          end
        end
        SEND: begin
          if (aw_hs) begin
            AWVALID_o <= 1'b0;
            aw_done   <= 1'b1;
          end
          if (w_hs) begin
            WVALID_o <= 1'b0;
            w_done   <= 1'b1;
          end
          if ((aw_done | aw_hs) & (w_done | w_hs)) begin
            state <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (BVALID_i) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
